// File: rtl/mem_access_unit_pkg.sv
// Shared bus/opcode definitions for the memory access unit: FSM state
// encodings, mem_sel size codes and the alignment rule.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_ERROR  = 2'd3
  } state_t;

  localparam logic [3:0] SEL_NONE = 4'b0000;
  localparam logic [3:0] SEL_BYTE = 4'b0001;
  localparam logic [3:0] SEL_WORD = 4'b1111;

  // Bytes are always aligned; words must sit on a 4-byte boundary.
  function automatic logic is_aligned(input logic [3:0] sel, input logic [1:0] byte_off);
    return (sel == SEL_BYTE) || ((sel == SEL_WORD) && (byte_off == 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Purely combinational load alignment: selects the addressed byte lane of a
// bus word and sign- or zero-extends it; words pass straight through.
module load_align (
  input  logic [31:0] rdata,
  input  logic [1:0]  byte_off,
  input  logic        is_byte,
  input  logic        sign_ext,
  output logic [31:0] data
);

  logic [7:0] lane;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    lane = rdata[{byte_off, 3'b000} +: 8];
    data = rdata;
    if (is_byte) begin
      data = {{24{sign_ext & lane[7]}}, lane};
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline and a ready-handshake RAM bus. Stalls
// the pipeline for the duration of each access and reports misaligned words
// and bus timeouts as a one-cycle addr_error pulse.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int RAM_WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_flag,
  input  logic        mem_write_flag,
  input  logic        mem_sign_ext_flag,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_write_data,
  input  logic [31:0] address,
  output logic        ram_en,
  output logic [3:0]  ram_write_en,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_write_data,
  input  logic [31:0] ram_read_data,
  input  logic        ram_ready,
  output logic        stall_request,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        addr_error
);

  localparam int CW = (RAM_WAIT_MAX < 2) ? 1 : $clog2(RAM_WAIT_MAX + 1);

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt;

  // Request captured on entry to ACCESS so the bus stays stable while waiting.
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_we;
  logic        req_store;
  logic        req_byte;
  logic        req_sign;

  logic        request;
  logic        start_access;
  logic [31:0] aligned_data;

  assign request      = (mem_sel != SEL_NONE) && (mem_read_flag || mem_write_flag);
  assign start_access = (state == ST_IDLE) && request && is_aligned(mem_sel, address[1:0]);

  load_align u_load_align (
    .rdata    (ram_read_data),
    .byte_off (req_addr[1:0]),
    .is_byte  (req_byte),
    .sign_ext (req_sign),
    .data     (aligned_data)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      load_data <= '0;
      // NOTE: the captured request is reset too; it is only a handful of flops, not a memory array.
      req_addr  <= '0;
      req_wdata <= '0;
      req_we    <= '0;
      req_store <= 1'b0;
      req_byte  <= 1'b0;
      req_sign  <= 1'b0;
    end else begin
      state <= state_next;

      if ((state == ST_ACCESS) && !ram_ready) wait_cnt <= wait_cnt + 1'b1;
      else                                    wait_cnt <= '0;

      if (start_access) begin
        req_addr  <= address;
        req_store <= mem_write_flag;
        req_byte  <= (mem_sel == SEL_BYTE);
        req_sign  <= mem_sign_ext_flag;
        if (!mem_write_flag) begin
          req_we    <= 4'b0000;
          req_wdata <= '0;
        end else if (mem_sel == SEL_BYTE) begin
          req_we    <= 4'b0001 << address[1:0];
          req_wdata <= {4{mem_write_data[7:0]}};
        end else begin
          req_we    <= 4'b1111;
          req_wdata <= mem_write_data;
        end
      end

      if ((state == ST_ACCESS) && ram_ready && !req_store) load_data <= aligned_data;
    end
  end

  always_comb begin
    state_next     = state;
    ram_en         = 1'b0;
    ram_write_en   = 4'b0000;
    ram_addr       = '0;
    ram_write_data = '0;
    stall_request  = 1'b0;
    load_valid     = 1'b0;
    addr_error     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        stall_request = request;
        if (request) state_next = is_aligned(mem_sel, address[1:0]) ? ST_ACCESS : ST_ERROR;
      end
      ST_ACCESS: begin
        ram_en         = 1'b1;
        stall_request  = 1'b1;
        ram_addr       = {req_addr[31:2], 2'b00};
        ram_write_en   = req_we;
        ram_write_data = req_wdata;
        if (ram_ready)                                state_next = ST_DONE;
        else if (wait_cnt == CW'(RAM_WAIT_MAX - 1)) state_next = ST_ERROR;
      end
      // The request still visible in DONE is the stale instruction; ignore it.
      ST_DONE: begin
        load_valid = !req_store;
        state_next = ST_IDLE;
      end
      ST_ERROR: begin
        addr_error = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: RAM_WAIT_MAX, default 255, meaning: cycles waited for ram_ready before a bus error is raised.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 mem_read_flag  input  1  load request from the decode memory-control generator.
REQ-005 mem_write_flag  input  1  store request.
REQ-006 mem_sign_ext_flag  input  1  load result is sign-extended when 1, zero-extended when 0.
REQ-007 mem_sel  input  4  access size: 0001 byte, 1111 word, 0000 no access.
REQ-008 mem_write_data  input  32  store data; a byte store uses bits [7:0].
REQ-009 address  input  32  effective address from the ALU result.
REQ-010 ram_en  output  1  bus request.
REQ-011 ram_write_en  output  4  byte-lane write strobes.
REQ-012 ram_addr  output  32  word-aligned bus address.
REQ-013 ram_write_data  output  32  lane-replicated store data.
REQ-014 ram_read_data  input  32  bus read data; valid while ram_ready=1.
REQ-015 ram_ready  input  1  bus completion strobe.
REQ-016 stall_request  output  1  freezes upstream pipeline registers.
REQ-017 load_data  output  32  aligned and extended load result.
REQ-018 load_valid  output  1  load_data is valid this cycle.
REQ-019 addr_error  output  1  one-cycle misalignment or bus-timeout pulse.

Function
REQ-020 The FSM SHALL have four states: IDLE, ACCESS, DONE and ERROR.
REQ-021 A request SHALL be present when mem_sel != 0 and mem_read_flag or mem_write_flag is 1; in IDLE with no request, all outputs SHALL be 0.
REQ-022 In IDLE, an aligned request SHALL move the FSM to ACCESS; aligned means mem_sel=0001, or mem_sel=1111 with address[1:0]=00.
REQ-023 A word request with address[1:0]!=00 SHALL move the FSM to ERROR, issue no bus cycle and assert no ram_en.
REQ-024 While the FSM is in ACCESS, ram_en SHALL be 1.
REQ-025 While the FSM is in ACCESS, ram_addr SHALL be {address[31:2],2'b00}.
REQ-026 While the FSM is in ACCESS, all bus outputs SHALL be held stable until ram_ready is sampled at 1.
REQ-027 Byte store: ram_write_en = 0001 << address[1:0]; ram_write_data = mem_write_data[7:0] replicated to all four lanes.
REQ-028 Word store: ram_write_en = 1111; ram_write_data = mem_write_data. Loads drive ram_write_en = 0000.
REQ-029 If mem_read_flag and mem_write_flag are both 1, the access SHALL be treated as a store.
REQ-030 When ram_ready=1 in ACCESS, a load SHALL register load_data; the FSM SHALL move to DONE and drop ram_en on the next cycle.
REQ-031 Byte load: byte = ram_read_data[8*address[1:0]+7 -: 8], extended to 32 bits according to mem_sign_ext_flag.
REQ-032 Word load: load_data = ram_read_data.
REQ-033 A ram_ready=1 that arrives in the first ACCESS cycle SHALL complete the access; minimum latency is request to DONE in 2 cycles.
REQ-034 If ACCESS lasts RAM_WAIT_MAX cycles without ram_ready, the FSM SHALL move to ERROR.
REQ-035 stall_request SHALL be combinationally 1 in IDLE with a request present, and 1 throughout ACCESS.
REQ-036 stall_request SHALL be 0 in DONE and in ERROR, so the pipeline advances exactly once per access.
REQ-037 In DONE, load_valid SHALL be 1 for exactly one cycle, for loads only; the FSM SHALL then return to IDLE.
REQ-038 A request present in DONE SHALL be ignored; it is the stale, pre-advance instruction.
REQ-039 In ERROR, addr_error SHALL be 1 for exactly one cycle; the FSM SHALL then return to IDLE.
REQ-040 load_data SHALL hold its last value until the next completed load.

Reset
REQ-041 When rst=0, the FSM SHALL asynchronously go to IDLE, the wait counter to 0, load_data to 0, and all outputs to 0.
REQ-042 Reset during ACCESS SHALL drop ram_en immediately; a ram_ready arriving afterwards SHALL be ignored.

Structure
REQ-043 The FSM state encodings and the mem_sel size codes (0001, 1111) SHALL live in the shared bus/opcode include.
REQ-044 Load byte-select and extension logic SHALL be one sub-module, load_align, that is purely combinational.

Verification
REQ-045 Word load, address=0x100, ram_ready after 3 cycles, data 0xDEADBEEF -> ram_addr=0x100, stall for 4 cycles, load_valid with load_data=0xDEADBEEF.
REQ-046 Byte load, signed, address=0x103, data 0x80FF1234 -> load_data=0xFFFFFF80; repeat unsigned -> load_data=0x00000080.
REQ-047 Byte store, address=0x201, data 0x000000A5 -> ram_write_en=0010, ram_write_data=0xA5A5A5A5, ram_addr=0x200, load_valid=0.
REQ-048 Word store, address=0x302 -> addr_error pulse of 1 cycle, ram_en never 1, stall_request 0 from the ERROR cycle onward.
REQ-049 ram_ready held 0 for RAM_WAIT_MAX cycles -> addr_error=1, then IDLE; separately, rst=0 mid-ACCESS -> ram_en=0 in the same cycle and the FSM in IDLE.
REQ-050 Back-to-back loads with ram_ready=1 constantly -> each access takes 2 cycles, with no re-issue of the first address in DONE.
